// File: rtl/bsearch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bsearch_pkg : shared types and defaults for the binary-search controller
// rev 1.0
// ---------------------------------------------------------------------------
package bsearch_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_SETTLE = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        FL_LT  = 2'd0,
        FL_GT  = 2'd1,
        FL_EQ  = 2'd2,
        FL_BAD = 2'd3
    } flag_e;

    // Anything other than exactly one flag set is an inconsistent comparator.
    function automatic flag_e decode_flags(input logic lt, input logic gt, input logic eq);
        flag_e f;
        case ({lt, gt, eq})
            3'b100:  f = FL_LT;
            3'b010:  f = FL_GT;
            3'b001:  f = FL_EQ;
            default: f = FL_BAD;
        endcase
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bsearch_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bsearch_ctrl_if : start/comparator-flag/result bundle of bsearch_ctrl
// rev 1.0
// ---------------------------------------------------------------------------
interface bsearch_ctrl_if
    import bsearch_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TW    = $clog2(WIDTH + 2)
);
    logic             start;
    logic             A_lt_B;
    logic             A_gt_B;
    logic             A_eq_B;
    logic [WIDTH-1:0] guess;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] found;
    logic [TW-1:0]    tries;

    modport master (
        output start, A_lt_B, A_gt_B, A_eq_B,
        input  guess, busy, done, err, found, tries
    );

    modport slave (
        input  start, A_lt_B, A_gt_B, A_eq_B,
        output guess, busy, done, err, found, tries
    );
endinterface
`default_nettype wire

// File: rtl/bsearch_bounds.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bsearch_bounds : next lo/hi/midpoint for one comparator verdict
// rev 1.0
// ---------------------------------------------------------------------------
module bsearch_bounds
    import bsearch_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] guess_i,
    input  flag_e            flag_i,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] mid_o,
    output logic             err_o
);
    logic [WIDTH:0] w_sum;

    // The edge checks flag the cases where +1/-1 would wrap; the wrapped
    // bound is then never committed.
    always_comb begin
        lo_o  = lo_i;
        hi_o  = hi_i;
        err_o = 1'b0;
        case (flag_i)
            FL_LT: begin
                err_o = (guess_i == hi_i);
                lo_o  = guess_i + WIDTH'(1);
            end
            FL_GT: begin
                err_o = (guess_i == lo_i);
                hi_o  = guess_i - WIDTH'(1);
            end
            default: ;
        endcase
        w_sum = {1'b0, lo_o} + {1'b0, hi_o};
        mid_o = w_sum[WIDTH:1];
    end

endmodule
`default_nettype wire

// File: rtl/bsearch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bsearch_ctrl : binary search of a hidden comparator operand
// rev 1.0
// ---------------------------------------------------------------------------
module bsearch_ctrl
    import bsearch_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SETTLE = DEF_SETTLE,
    parameter int TW     = $clog2(WIDTH + 2)
) (
    input  logic          CLK,
    input  logic          nRST,
    bsearch_ctrl_if.slave bus
);
    localparam int               CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]    CNT_LOAD = CW'(SETTLE - 1);
    localparam logic [WIDTH-1:0] MAXV     = '1;
    localparam logic [WIDTH-1:0] MID0     = MAXV >> 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
    logic [WIDTH-1:0] guess_q, guess_d, found_q, found_d;
    logic [TW-1:0]    tries_q, tries_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;

    flag_e            w_flag;
    logic [WIDTH-1:0] w_lo_n, w_hi_n, w_mid_n;
    logic             w_bnd_err;

    assign w_flag = decode_flags(bus.A_lt_B, bus.A_gt_B, bus.A_eq_B);

    bsearch_bounds #(.WIDTH(WIDTH)) u_bounds (
        .lo_i    (lo_q),
        .hi_i    (hi_q),
        .guess_i (guess_q),
        .flag_i  (w_flag),
        .lo_o    (w_lo_n),
        .hi_o    (w_hi_n),
        .mid_o   (w_mid_n),
        .err_o   (w_bnd_err)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            lo_q    <= '0;
            hi_q    <= MAXV;
            guess_q <= '0;
            found_q <= '0;
            tries_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            guess_q <= guess_d;
            found_q <= found_d;
            tries_q <= tries_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        guess_d = guess_q;
        found_d = found_q;
        tries_d = tries_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    lo_d    = '0;
                    hi_d    = MAXV;
                    guess_d = MID0;
                    tries_d = '0;
                    cnt_d   = CNT_LOAD;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    // Counter expired: this edge is the evaluation edge.
                    tries_d = tries_q + TW'(1);
                    case (w_flag)
                        FL_EQ: begin
                            found_d = guess_q;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_DONE;
                        end
                        FL_LT, FL_GT: begin
                            if (w_bnd_err) begin
                                err_d   = 1'b1;
                                busy_d  = 1'b0;
                                state_d = S_ERR;
                            end else begin
                                lo_d    = w_lo_n;
                                hi_d    = w_hi_n;
                                guess_d = w_mid_n;
                                cnt_d   = CNT_LOAD;
                            end
                        end
                        default: begin
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_ERR;
                        end
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.guess = guess_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.found = found_q;
    assign bus.tries = tries_q;

endmodule
`default_nettype wire
